// File: rtl/burst_fetch_if.sv
// Memory read-request/response port and on-chip buffer write port of the burst fetch unit.
// master: fetch engine side; slave: memory / buffer side.
interface burst_fetch_if #(
  parameter int DATA_W     = 128,
  parameter int SRC_ADDR_W = 32,
  parameter int DST_ADDR_W = 15,
  parameter int BANK_W     = 1
);
  logic                  rd_en;
  logic [SRC_ADDR_W-1:0] rd_addr;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_en;
  logic [DST_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [BANK_W-1:0]     wr_bank;

  modport master (
    output rd_en, rd_addr,
    input  rd_ready, rd_valid, rd_data,
    output wr_en, wr_addr, wr_data, wr_bank
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_ready, rd_valid, rd_data,
    input  wr_en, wr_addr, wr_data, wr_bank
  );
endinterface

// File: rtl/burst_fetch.sv
// Burst fetch engine: moves burst_len beats from the external read port into a buffer bank,
// with a bounded number of outstanding reads and a completion pulse after the last write.
module burst_fetch #(
  parameter int                    DATA_W          = 128,
  parameter int                    SRC_ADDR_W      = 32,
  parameter int                    DST_ADDR_W      = 15,
  parameter int                    LEN_W           = 8,
  parameter logic [SRC_ADDR_W-1:0] ADDR_OFFSET     = '0,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter int                    NUM_BANKS       = 2,
  localparam int                   BANK_W          = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_enable,
  input  logic [SRC_ADDR_W-1:0] src_addr,
  input  logic [DST_ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic [BANK_W-1:0]     mem_sel,
  burst_fetch_if.master         bus,
  output logic                  busy,
  output logic                  fetch_done,
  output logic                  resp_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int              OUT_W   = 4;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  logic [1:0]            state, state_nxt;
  logic [LEN_W-1:0]      len_q, len_nxt;
  logic [LEN_W-1:0]      issued, issued_nxt;
  logic [LEN_W-1:0]      received, received_nxt;
  logic [OUT_W-1:0]      outst, outst_nxt;
  logic [DST_ADDR_W-1:0] dst_q;
  logic [BANK_W-1:0]     bank_q;
  logic                  rd_en_p0, rd_en_nxt;
  logic [SRC_ADDR_W-1:0] rd_addr_p0;
  logic                  start, issue, in_burst, accept, drop;
  logic                  wr_en_p1;
  logic [DST_ADDR_W-1:0] wr_addr_p1;
  logic [DATA_W-1:0]     wr_data_p1;
  logic [BANK_W-1:0]     wr_bank_p1;

  always_comb begin
    start    = (state == S_IDLE) && fetch_enable;
    issue    = rd_en_p0 && bus.rd_ready;
    in_burst = (state == S_ISSUE) || (state == S_DRAIN);
    accept   = bus.rd_valid && in_burst && (received < len_q);
    drop     = bus.rd_valid && !accept;

    len_nxt      = start ? burst_len : len_q;
    issued_nxt   = start ? '0 : issued + LEN_W'(issue);
    received_nxt = start ? '0 : received + LEN_W'(accept);

    // Guarded decrement keeps a stray early response from wrapping the count and stalling issue.
    outst_nxt = outst;
    if (start)
      outst_nxt = '0;
    else if (issue && !accept)
      outst_nxt = outst + OUT_W'(1);
    else if (!issue && accept && (outst != '0))
      outst_nxt = outst - OUT_W'(1);

    state_nxt = state;
    case (state)
      S_IDLE:  if (fetch_enable) state_nxt = (burst_len == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (received_nxt == len_q)    state_nxt = S_DONE;
        else if (issued_nxt == len_q) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (received_nxt == len_q) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase

    // Registered request valid derived from next-cycle state, so it only drops after an accepted issue.
    rd_en_nxt = (state_nxt == S_ISSUE) && (issued_nxt < len_nxt) && (outst_nxt < OUT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      issued     <= '0;
      received   <= '0;
      outst      <= '0;
      dst_q      <= '0;
      bank_q     <= '0;
      rd_en_p0   <= 1'b0;
      rd_addr_p0 <= '0;
      resp_err   <= 1'b0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      wr_bank_p1 <= '0;
    end else begin
      // p0: request issue and burst bookkeeping
      state    <= state_nxt;
      len_q    <= len_nxt;
      issued   <= issued_nxt;
      received <= received_nxt;
      outst    <= outst_nxt;
      rd_en_p0 <= rd_en_nxt;
      if (start) begin
        rd_addr_p0 <= src_addr + ADDR_OFFSET;
        dst_q      <= dst_addr;
        bank_q     <= mem_sel;
      end else if (issue) begin
        rd_addr_p0 <= rd_addr_p0 + SRC_ADDR_W'(1);
      end
      if (drop)
        resp_err <= 1'b1;
      // p1: buffer write of the captured response
      wr_en_p1 <= accept;
      if (accept) begin
        wr_addr_p1 <= dst_q + DST_ADDR_W'(received);
        wr_data_p1 <= bus.rd_data;
        wr_bank_p1 <= bank_q;
      end
    end
  end

  assign bus.rd_en   = rd_en_p0;
  assign bus.rd_addr = rd_addr_p0;
  assign bus.wr_en   = wr_en_p1;
  assign bus.wr_addr = wr_addr_p1;
  assign bus.wr_data = wr_data_p1;
  assign bus.wr_bank = wr_bank_p1;
  assign busy        = (state != S_IDLE);
  assign fetch_done  = (state == S_DONE);
endmodule

// File: tb/tb_burst_fetch.sv
// Directed bench for burst_fetch: vector table of bursts plus hand-timed corner sequences.
module tb_burst_fetch;
  localparam int DW  = 32;
  localparam int SW  = 32;
  localparam int DAW = 15;
  localparam int LW  = 8;
  localparam int BW  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_enable = 1'b0;
  logic [SW-1:0] src_addr = '0;
  logic [DAW-1:0] dst_addr = '0;
  logic [LW-1:0] burst_len = '0;
  logic [BW-1:0] mem_sel = '0;
  logic          busy, fetch_done, resp_err;

  burst_fetch_if #(.DATA_W(DW), .SRC_ADDR_W(SW), .DST_ADDR_W(DAW), .BANK_W(BW)) bus ();

  burst_fetch #(
    .DATA_W(DW), .SRC_ADDR_W(SW), .DST_ADDR_W(DAW), .LEN_W(LW),
    .ADDR_OFFSET('0), .MAX_OUTSTANDING(4), .NUM_BANKS(2)
  ) dut (
    .clk(clk), .rst(rst), .fetch_enable(fetch_enable),
    .src_addr(src_addr), .dst_addr(dst_addr), .burst_len(burst_len), .mem_sel(mem_sel),
    .bus(bus), .busy(busy), .fetch_done(fetch_done), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] datafn(input logic [SW-1:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Memory model: in-order responses, configurable latency, optional ready toggling.
  typedef struct { int due; logic [SW-1:0] addr; } rsp_t;
  rsp_t rq[$];
  int   cyc = 0;
  int   lat = 1;
  bit   rmode = 1'b0;
  bit   inj = 1'b0;

  initial begin
    bus.rd_ready = 1'b1;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    forever begin
      @(negedge clk);
      bus.rd_ready = rmode ? ~bus.rd_ready : 1'b1;
      bus.rd_valid = 1'b0;
      if (inj) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = 32'hDEAD_BEEF;
        inj = 1'b0;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = datafn(rq[0].addr);
        rq.delete(0);
      end
    end
  end

  // Monitor: logs issues and writes, tracks outstanding and stall stability.
  logic [DAW-1:0] wa_q[$];
  logic [DW-1:0]  wd_q[$];
  logic [BW-1:0]  wb_q[$];
  logic [SW-1:0]  ia_q[$];
  int done_cnt, done_nowr, n_iss, n_rsp, max_out, stall_bad;
  bit prev_stall;
  logic [SW-1:0] prev_addr;

  always @(posedge clk) begin
    rsp_t r;
    cyc++;
    if (rst) begin
      if (bus.rd_en && bus.rd_ready) begin
        r.due  = cyc + lat - 1;
        r.addr = bus.rd_addr;
        rq.push_back(r);
        ia_q.push_back(bus.rd_addr);
        n_iss++;
      end
      if (bus.rd_valid) n_rsp++;
      if (n_iss - n_rsp > max_out) max_out = n_iss - n_rsp;
      if (bus.wr_en) begin
        wa_q.push_back(bus.wr_addr);
        wd_q.push_back(bus.wr_data);
        wb_q.push_back(bus.wr_bank);
      end
      if (fetch_done) begin
        done_cnt++;
        if (!bus.wr_en) done_nowr++;
      end
      if (prev_stall && !(bus.rd_en && bus.rd_addr == prev_addr)) stall_bad++;
      prev_stall = bus.rd_en && !bus.rd_ready;
      prev_addr  = bus.rd_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wb_q.delete(); ia_q.delete();
    done_cnt = 0; done_nowr = 0; n_iss = 0; n_rsp = 0; max_out = 0; stall_bad = 0;
  endtask

  task automatic start_fetch(input logic [SW-1:0] s, input logic [DAW-1:0] d,
                             input logic [LW-1:0] l, input logic [BW-1:0] m);
    @(negedge clk);
    src_addr = s; dst_addr = d; burst_len = l; mem_sel = m; fetch_enable = 1'b1;
    @(negedge clk);
    fetch_enable = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_beats(input string name, input logic [SW-1:0] s, input logic [DAW-1:0] d,
                             input logic [BW-1:0] m);
    logic [DAW-1:0] ea;
    logic [SW-1:0]  es;
    for (int j = 0; j < wa_q.size(); j++) begin
      ea = d + DAW'(j);
      es = s + SW'(j);
      check($sformatf("%s_wa%0d", name, j), 64'(wa_q[j]), 64'(ea));
      check($sformatf("%s_wd%0d", name, j), 64'(wd_q[j]), 64'(datafn(es)));
      check($sformatf("%s_wb%0d", name, j), 64'(wb_q[j]), 64'(m));
    end
    for (int j = 0; j < ia_q.size(); j++) begin
      es = s + SW'(j);
      check($sformatf("%s_ra%0d", name, j), 64'(ia_q[j]), 64'(es));
    end
  endtask

  typedef struct {
    logic [SW-1:0]  src;
    logic [DAW-1:0] dst;
    logic [LW-1:0]  len;
    logic [BW-1:0]  sel;
    int             lat;
    bit             rm;
    int             exp_n;
    logic [DAW-1:0] exp_last_wa;
    logic [SW-1:0]  exp_last_ra;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DAW-1:0] last_wa;
    logic [SW-1:0]  last_ra;

    tbl[0] = '{32'h0000_0100, 15'h0020, 8'd8,   1'b0, 3, 1'b1, 8,   15'h0027, 32'h0000_0107};
    tbl[1] = '{32'h0000_0200, 15'h0040, 8'd10,  1'b1, 8, 1'b0, 10,  15'h0049, 32'h0000_0209};
    tbl[2] = '{32'h0000_0300, 15'h7FFE, 8'd4,   1'b1, 1, 1'b0, 4,   15'h0001, 32'h0000_0303};
    tbl[3] = '{32'hFFFF_FFFE, 15'h0010, 8'd3,   1'b0, 2, 1'b1, 3,   15'h0012, 32'h0000_0000};
    tbl[4] = '{32'h0000_1000, 15'h0000, 8'd255, 1'b1, 1, 1'b0, 255, 15'h00FE, 32'h0000_10FE};

    clear_log();
    #1;
    check("rst_rd_en", 64'(bus.rd_en), 64'd0);
    check("rst_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(fetch_done), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single beat, minimum latency
    clear_log(); lat = 1; rmode = 1'b0;
    @(negedge clk);
    src_addr = 32'h100; dst_addr = 15'h20; burst_len = 8'd1; mem_sel = 1'b1; fetch_enable = 1'b1;
    @(posedge clk); #1;
    fetch_enable = 1'b0;
    check("sb_t1_rd_en", 64'(bus.rd_en), 64'd1);
    check("sb_t1_rd_addr", 64'(bus.rd_addr), 64'h100);
    check("sb_t1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("sb_t2_rd_en", 64'(bus.rd_en), 64'd0);
    check("sb_t2_wr_en", 64'(bus.wr_en), 64'd0);
    @(posedge clk); #1;
    check("sb_t3_wr_en", 64'(bus.wr_en), 64'd1);
    check("sb_t3_wr_addr", 64'(bus.wr_addr), 64'h20);
    check("sb_t3_wr_bank", 64'(bus.wr_bank), 64'd1);
    check("sb_t3_wr_data", 64'(bus.wr_data), 64'(datafn(32'h100)));
    check("sb_t3_done", 64'(fetch_done), 64'd1);
    @(posedge clk); #1;
    check("sb_t4_busy", 64'(busy), 64'd0);
    check("sb_t4_done", 64'(fetch_done), 64'd0);
    check("sb_nwr", 64'(wa_q.size()), 64'd1);

    // Zero length
    repeat (2) @(negedge clk);
    clear_log();
    @(negedge clk);
    src_addr = 32'h400; dst_addr = 15'h10; burst_len = 8'd0; mem_sel = 1'b0; fetch_enable = 1'b1;
    @(posedge clk); #1;
    fetch_enable = 1'b0;
    check("z_t1_done", 64'(fetch_done), 64'd1);
    check("z_t1_rd_en", 64'(bus.rd_en), 64'd0);
    @(posedge clk); #1;
    check("z_t2_done", 64'(fetch_done), 64'd0);
    check("z_t2_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("z_niss", 64'(n_iss), 64'd0);
    check("z_nwr", 64'(wa_q.size()), 64'd0);
    check("z_ndone", 64'(done_cnt), 64'd1);

    // Table of bursts
    for (int i = 0; i < 5; i++) begin
      clear_log();
      lat = tbl[i].lat;
      rmode = tbl[i].rm;
      start_fetch(tbl[i].src, tbl[i].dst, tbl[i].len, tbl[i].sel);
      wait_done($sformatf("v%0d", i), 3000);
      rmode = 1'b0;
      last_wa = (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : '1;
      last_ra = (ia_q.size() > 0) ? ia_q[ia_q.size()-1] : '1;
      check($sformatf("v%0d_nwr", i), 64'(wa_q.size()), 64'(tbl[i].exp_n));
      check($sformatf("v%0d_niss", i), 64'(n_iss), 64'(tbl[i].exp_n));
      check($sformatf("v%0d_last_wa", i), 64'(last_wa), 64'(tbl[i].exp_last_wa));
      check($sformatf("v%0d_last_ra", i), 64'(last_ra), 64'(tbl[i].exp_last_ra));
      check($sformatf("v%0d_ndone", i), 64'(done_cnt), 64'd1);
      check($sformatf("v%0d_done_wr", i), 64'(done_nowr), 64'd0);
      check($sformatf("v%0d_stall", i), 64'(stall_bad), 64'd0);
      check($sformatf("v%0d_outst_ok", i), 64'(max_out <= 4), 64'd1);
      if (i == 1) check("v1_outst_max", 64'(max_out), 64'd4);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      check_beats($sformatf("v%0d", i), tbl[i].src, tbl[i].dst, tbl[i].sel);
    end

    // fetch_enable mid-burst is ignored
    clear_log(); lat = 2;
    start_fetch(32'h500, 15'h50, 8'd8, 1'b0);
    repeat (2) @(negedge clk);
    src_addr = 32'h900; dst_addr = 15'h90; burst_len = 8'd3; fetch_enable = 1'b1;
    @(negedge clk);
    fetch_enable = 1'b0;
    wait_done("ab", 500);
    repeat (10) @(negedge clk);
    check("ab_nwr", 64'(wa_q.size()), 64'd8);
    check("ab_niss", 64'(n_iss), 64'd8);
    check("ab_ndone", 64'(done_cnt), 64'd1);
    check("ab_busy", 64'(busy), 64'd0);
    check_beats("ab", 32'h500, 15'h50, 1'b0);

    // Response in IDLE sets the sticky error
    check("err_before", 64'(resp_err), 64'd0);
    inj = 1'b1;
    repeat (3) @(negedge clk);
    check("err_after", 64'(resp_err), 64'd1);
    check("err_nwr", 64'(wa_q.size()), 64'd8);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(resp_err), 64'd1);

    // Reset mid-burst
    clear_log(); lat = 1;
    start_fetch(32'h700, 15'h70, 8'd8, 1'b1);
    for (int n = 0; n < 50 && wa_q.size() < 3; n++) @(negedge clk);
    check("rb_3beats", 64'(wa_q.size() >= 3), 64'd1);
    rst = 1'b0;
    rq.delete();
    #1;
    check("rb_rd_en", 64'(bus.rd_en), 64'd0);
    check("rb_rd_addr", 64'(bus.rd_addr), 64'd0);
    check("rb_wr_en", 64'(bus.wr_en), 64'd0);
    check("rb_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rb_wr_data", 64'(bus.wr_data), 64'd0);
    check("rb_busy", 64'(busy), 64'd0);
    check("rb_done", 64'(fetch_done), 64'd0);
    check("rb_err_clr", 64'(resp_err), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rb_no_done", 64'(done_cnt), 64'd0);
    check("rb_idle", 64'(busy), 64'd0);

    clear_log();
    start_fetch(32'h800, 15'h80, 8'd2, 1'b0);
    wait_done("ar", 200);
    check("ar_nwr", 64'(wa_q.size()), 64'd2);
    check("ar_niss", 64'(n_iss), 64'd2);
    check("ar_ndone", 64'(done_cnt), 64'd1);
    check_beats("ar", 32'h800, 15'h80, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/burst_fetch.md
Name: burst_fetch

Overview:
Parametrised successor to the single-beat feature/weight fetch units. On one instruction pulse it moves a burst of N beats from the external memory read port into an on-chip buffer bank. It uses a valid/ready request handshake, bounds the number of outstanding reads, and raises fetch_done only after the last beat has actually been written. It sits between the instruction parser/top FSM and the feature_in or weight buffers, and replaces the fixed 3-cycle done pipeline.

Parameters:
DATA_W, 128, width of read data and buffer write data
SRC_ADDR_W, 32, external read address width
DST_ADDR_W, 15, on-chip buffer write address width
LEN_W, 8, burst length field width
ADDR_OFFSET, 0, constant added to every read address
MAX_OUTSTANDING, 4, maximum issued-but-unreturned reads (1..15)
NUM_BANKS, 2, selectable destination banks (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
fetch_enable  in  1  start pulse, sampled only in IDLE
src_addr  in  SRC_ADDR_W  first external read address
dst_addr  in  DST_ADDR_W  first buffer write address
burst_len  in  LEN_W  number of beats; 0 means no transfer
mem_sel  in  log2(NUM_BANKS)  destination bank
rd_en  out  1  read request valid
rd_addr  out  SRC_ADDR_W  read request address
rd_ready  in  1  read request accepted when high with rd_en
rd_valid  in  1  read response valid; responses return in order
rd_data  in  DATA_W  read response data
wr_en  out  1  buffer write strobe
wr_addr  out  DST_ADDR_W  buffer write address
wr_data  out  DATA_W  buffer write data
wr_bank  out  log2(NUM_BANKS)  buffer bank select
busy  out  1  high whenever the state is not IDLE
fetch_done  out  1  one-cycle completion pulse
resp_err  out  1  sticky flag for an unexpected response

Behaviour:
- Reset (rst=0, asynchronous): all outputs and registers are 0, state is IDLE. A reset asserted mid-burst aborts the burst with no fetch_done. After reset, resp_err clears only through reset.
- States are IDLE, ISSUE, DRAIN, DONE.
- IDLE, fetch_enable=1: latch src_addr+ADDR_OFFSET, dst_addr, burst_len and mem_sel. Clear the issued, received and outstanding counters.
  - burst_len=0: go to DONE.
  - otherwise: go to ISSUE.
- fetch_enable is ignored outside IDLE. There is no queuing.
- Read requests:
  - rd_en and rd_addr are registered.
  - A beat is issued on each edge where rd_en=1 and rd_ready=1.
  - On that edge rd_addr increments by 1, wrapping modulo 2^SRC_ADDR_W, and the issued count increments.
  - rd_en must stay stable while rd_ready=0.
  - rd_en=1 iff state=ISSUE, issued<len and outstanding<MAX_OUTSTANDING.
  - When issued reaches len, go to DRAIN.
- Outstanding count:
  - +1 on an issue, -1 on a counted response.
  - Both on the same edge leaves it unchanged.
- Responses:
  - Each rd_valid with received<len, in ISSUE or DRAIN, produces one write one cycle later.
  - The write is wr_en=1, wr_data=rd_data (registered), wr_addr=dst+received (modulo 2^DST_ADDR_W) and wr_bank=latched mem_sel.
  - Each such response then increments received.
- rd_valid in IDLE or DONE, or with received=len: the response is dropped, resp_err is set and no write occurs.
- When received reaches len, go to DONE. This happens on the same edge as the last response is captured, so the final wr_en appears while in DONE.
- DONE: fetch_done=1 for exactly one cycle, then IDLE.
  - For len>0, fetch_done coincides with the final wr_en.
  - For len=0, fetch_done is asserted the cycle after acceptance.
  - busy drops the cycle after fetch_done.
- Minimum latency:
  - len=1 with rd_ready tied high and 1-cycle memory response: rd_en is asserted at T+1 after fetch_enable at T.
  - Response arrives at T+2; wr_en and fetch_done at T+3.
- Throughput is one beat per cycle when rd_ready=1 and response latency is at most MAX_OUTSTANDING cycles.
- len=2^LEN_W-1 is supported. Counters are LEN_W bits and never overflow.

Test Plan:
- Single beat: src=0x100, dst=0x20, len=1, mem_sel=1, rd_ready=1, response latency 1 -> rd_en at T+1 with rd_addr=0x100; wr_en, wr_addr=0x20, wr_bank=1 and fetch_done at T+3; busy low at T+4.
- Burst with backpressure: len=8, rd_ready toggling 1/0, response latency 3 -> exactly 8 requests at addresses 0x100..0x107, rd_en/rd_addr held while stalled, 8 writes to 0x20..0x27 in order, one fetch_done.
- Outstanding limit: MAX_OUTSTANDING=4, len=10, response latency 8 -> rd_en deasserts after 4 issues, never more than 4 outstanding, all 10 beats written.
- Wrap and zero length: dst=0x7FFE, len=4 -> writes to 0x7FFE, 0x7FFF, 0x0000, 0x0001. Separately, len=0 -> fetch_done at T+1, no rd_en, no wr_en.
- Abuse: fetch_enable pulsed mid-burst -> ignored. rd_valid in IDLE -> resp_err=1, no wr_en.
- Reset mid-burst: rst low after 3 of 8 beats -> all outputs 0 immediately, no fetch_done; a new len=2 fetch after reset completes normally.
